transmit: RTL

Serial transmitter that feeds the team's one-bit-per-clock serial receiver.
- Accepts parallel bytes over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte as: start bit (0), 8 data bits MSB first, stop bit (1). The line idles high.
- Frames are sent back-to-back with no idle gap while the FIFO holds data. Sits directly upstream of the receiver's rxd input.

---
 rtl/transmit_pkg.sv | 9 +
 rtl/transmit_if.sv | 14 +
 rtl/transmit_tx_fifo.sv | 37 +++
 rtl/transmit.sv | 97 +++++++++
 4 files changed

// File: rtl/transmit_pkg.sv
// transmit_pkg: shared state type, line levels and frame geometry for the serial transmitter.
package transmit_pkg;
   localparam int DEF_DATA_W = 8;
   localparam int FRAME_BITS = DEF_DATA_W + 2;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/transmit_if.sv
// transmit_if: byte handshake plus serial line and status bundle between a byte source and the transmitter.
interface transmit_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH = 4
) ();
   logic [DATA_W-1:0] data_in;
   logic data_valid;
   logic data_ready;
   logic txd;
   logic busy;
   logic [$clog2(DEPTH):0] fifo_count;
   modport master (output data_in, data_valid, input data_ready, txd, busy, fifo_count);
   modport slave (input data_in, data_valid, output data_ready, txd, busy, fifo_count);
endinterface

// File: rtl/transmit_tx_fifo.sv
// tx_fifo: power-of-two synchronous FIFO with occupancy count; caller must not push when full or pop when empty.
module tx_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH = 4
) (
   input logic clk,
   input logic rst,
   input logic i_push,
   input logic [DATA_W-1:0] i_data,
   input logic i_pop,
   output logic [DATA_W-1:0] o_data,
   output logic [$clog2(DEPTH):0] o_count,
   output logic o_full
);
   localparam int AW = $clog2(DEPTH);
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0] r_count;
   assign o_data = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full = r_count == (AW+1)'(DEPTH);
   // storage has no reset; only entries below the count are ever read
   always_ff @(posedge clk)
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   // pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
      end
   a_no_empty_pop: assert property (@(posedge clk) disable iff (rst) !(i_pop && r_count == '0));
endmodule

// File: rtl/transmit.sv
// transmit: FIFO-fed serialiser sending start bit, MSB-first data and stop bit back-to-back.
// Define TX_FRAME_CNT_EN to add frame_cnt, a wrapping 16-bit count of completed frames.
module transmit
   import transmit_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH = 4,
   parameter int CLKS_PER_BIT = 1
) (
   input logic clk,
   input logic rst,
   transmit_if.slave bus
`ifdef TX_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam int BW = $clog2(DATA_W + 1);
   tx_state_t r_state;
   logic r_txd;
   logic [DATA_W-1:0] r_shreg, w_head;
   logic [BW-1:0] r_bit_cnt;
   logic [CW-1:0] r_clk_cnt;
   logic [AW:0] w_count;
   logic w_full, w_push, w_pop, w_have, w_bit_end;
   assign w_have = w_count != '0;
   assign w_bit_end = r_clk_cnt == CW'(CLKS_PER_BIT - 1);
   assign w_push = bus.data_valid && !w_full;
   assign w_pop = w_have && (r_state == IDLE || (r_state == STOP && w_bit_end));
   assign bus.data_ready = !w_full;
   assign bus.txd = r_txd;
   assign bus.busy = (r_state != IDLE) || w_have;
   assign bus.fifo_count = w_count;
   tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .i_push(w_push),
      .i_data(bus.data_in),
      .i_pop(w_pop),
      .o_data(w_head),
      .o_count(w_count),
      .o_full(w_full)
   );
   // frame sequencer; the stop period chains straight into the next start when data is waiting
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= IDLE;
         r_txd <= IDLE_LEVEL;
         r_shreg <= '0;
         r_bit_cnt <= '0;
         r_clk_cnt <= '0;
      end else begin
         r_clk_cnt <= (r_state == IDLE || w_bit_end) ? '0 : r_clk_cnt + 1'b1;
         case (r_state)
            IDLE:
               if (w_have) begin
                  r_shreg <= w_head;
                  r_txd <= START_BIT;
                  r_state <= START;
               end
            START:
               if (w_bit_end) begin
                  r_txd <= r_shreg[DATA_W-1];
                  r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
                  r_bit_cnt <= BW'(1);
                  r_state <= DATA;
               end
            DATA:
               if (w_bit_end) begin
                  if (r_bit_cnt < BW'(DATA_W)) begin
                     r_txd <= r_shreg[DATA_W-1];
                     r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end else begin
                     r_txd <= STOP_BIT;
                     r_state <= STOP;
                  end
               end
            default:
               if (w_bit_end) begin
                  r_shreg <= w_have ? w_head : r_shreg;
                  r_txd <= w_have ? START_BIT : IDLE_LEVEL;
                  r_state <= w_have ? START : IDLE;
               end
         endcase
      end
`ifdef TX_FRAME_CNT_EN
   logic [15:0] r_frame_cnt;
   assign frame_cnt = r_frame_cnt;
   // counts each finished stop period, wrapping at 16 bits
   always_ff @(posedge clk or posedge rst)
      if (rst) r_frame_cnt <= '0;
      else if (r_state == STOP && w_bit_end) r_frame_cnt <= r_frame_cnt + 1'b1;
`endif
endmodule
